// File: rtl/msu_pkg.sv
// Shared definitions for the MSU-1 control block: register offsets, ID string,
// audio state encodings and status bit positions.
package msu_pkg;

    localparam logic [2:0] OFF_STATUS   = 3'd0;
    localparam logic [2:0] OFF_DATA     = 3'd1;
    localparam logic [2:0] OFF_SEEK0    = 3'd0;
    localparam logic [2:0] OFF_SEEK1    = 3'd1;
    localparam logic [2:0] OFF_SEEK2    = 3'd2;
    localparam logic [2:0] OFF_SEEK3    = 3'd3;
    localparam logic [2:0] OFF_TRACK_LO = 3'd4;
    localparam logic [2:0] OFF_TRACK_HI = 3'd5;
    localparam logic [2:0] OFF_VOLUME   = 3'd6;
    localparam logic [2:0] OFF_CONTROL  = 3'd7;

    // Indexed directly by register offset; offsets 0 and 1 are never read from here.
    localparam logic [7:0] MSU_ID [0:7] = '{8'h00, 8'h00, 8'h53, 8'h2D,
                                            8'h4D, 8'h53, 8'h55, 8'h31};

    typedef enum logic [2:0] {
        AUD_IDLE    = 3'd0,
        AUD_REQ     = 3'd1,
        AUD_MOUNT   = 3'd2,
        AUD_READY   = 3'd3,
        AUD_MISSING = 3'd4
    } audio_state_t;

    localparam logic [2:0] ST_IDLE    = AUD_IDLE;
    localparam logic [2:0] ST_REQ     = AUD_REQ;
    localparam logic [2:0] ST_MOUNT   = AUD_MOUNT;
    localparam logic [2:0] ST_READY   = AUD_READY;
    localparam logic [2:0] ST_MISSING = AUD_MISSING;

    localparam int STAT_DATA_BUSY  = 7;
    localparam int STAT_AUDIO_BUSY = 6;
    localparam int STAT_REPEAT     = 5;
    localparam int STAT_PLAYING    = 4;
    localparam int STAT_MISSING    = 3;

endpackage

// File: rtl/msu_prefetch_fifo.sv
// Synchronous byte FIFO for the MSU data port prefetch; flush has priority over push/pop.
module msu_prefetch_fifo
    import msu_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          flush,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Overflowing pushes and underflowing pops are dropped so the pointers stay coherent.
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/msu_ctrl_v2.sv
// MSU-1 register/control block: data port with prefetch engine plus audio track FSM.
// Optional debug outputs (dbg_state, dbg_fifo_cnt, dbg_last_reg) exist only when MSU_DEBUG_EN is defined.
module msu_ctrl_v2
    import msu_pkg::*;
#(
    parameter  int         DADDR_W    = 32,
    parameter  int         FIFO_DEPTH = 8,
    parameter  int         TRACK_W    = 16,
    parameter  logic [2:0] REV        = 3'd2,
    localparam int         CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ENABLE,
    input  logic [23:0]        ADDR,
    input  logic               RD_N,
    input  logic               WR_N,
    input  logic [7:0]         DIN,
    output logic [7:0]         DOUT,
    output logic               mem_req,
    output logic [DADDR_W-1:0] mem_addr,
    input  logic               mem_ack,
    input  logic [7:0]         mem_rdata,
    output logic [TRACK_W-1:0] track_out,
    output logic               track_request,
    input  logic               track_mounting,
    input  logic               track_missing,
    input  logic               audio_playing,
    output logic               trig_play,
    output logic               trig_pause,
    output logic [7:0]         volume_out,
    output logic               repeat_out
`ifdef MSU_DEBUG_EN
    ,
    output logic [2:0]         dbg_state,
    output logic [CW-1:0]      dbg_fifo_cnt,
    output logic [7:0]         dbg_last_reg
`endif
);

    logic               wr_n_1, rd_n_1, rd_data_sel_1, audio_playing_1;
    logic               bank_ok, sel, wr_strobe, seek_wr, ack_ok, push, pop;
    logic [2:0]         off;
    logic [23:0]        seek;
    logic [DADDR_W-1:0] fetch_ptr;
    logic               seek_valid, drop_ack, data_busy;
    logic [CW-1:0]      fifo_cnt;
    logic [7:0]         fifo_dout, status, rd_mux, track_lo;
    logic [2:0]         state;
    logic               playing, missing, rpt, audio_busy;

    assign bank_ok    = (ADDR[23:16] < 8'h40) || (ADDR[23:16] >= 8'h80 && ADDR[23:16] < 8'hC0);
    assign sel        = ENABLE && bank_ok && (ADDR[15:3] == 13'h0400);
    assign off        = ADDR[2:0];
    assign wr_strobe  = wr_n_1 && !WR_N && sel;
    assign seek_wr    = wr_strobe && (off == OFF_SEEK3);
    assign ack_ok     = mem_ack && mem_req;
    assign push       = ack_ok && !drop_ack;
    assign pop        = !rd_n_1 && RD_N && rd_data_sel_1 && (fifo_cnt != '0);
    assign audio_busy = (state == ST_REQ) || (state == ST_MOUNT);
    assign repeat_out = rpt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_n_1          <= 1'b1;
            rd_n_1          <= 1'b1;
            rd_data_sel_1   <= 1'b0;
            audio_playing_1 <= 1'b0;
        end else begin
            wr_n_1          <= WR_N;
            rd_n_1          <= RD_N;
            rd_data_sel_1   <= !RD_N && sel && (off == OFF_DATA);
            audio_playing_1 <= audio_playing;
        end
    end

    msu_prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .flush (seek_wr),
        .push  (push),
        .din   (mem_rdata),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_cnt)
    );

    // A seek while a fetch is outstanding keeps mem_req up but discards that ack's byte.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seek       <= '0;
            fetch_ptr  <= '0;
            seek_valid <= 1'b0;
            drop_ack   <= 1'b0;
            data_busy  <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            if (wr_strobe) begin
                case (off)
                    OFF_SEEK0: seek[7:0]   <= DIN;
                    OFF_SEEK1: seek[15:8]  <= DIN;
                    OFF_SEEK2: seek[23:16] <= DIN;
                    default:   ;
                endcase
            end
            if (ack_ok) begin
                mem_req  <= 1'b0;
                drop_ack <= 1'b0;
                if (!drop_ack) fetch_ptr <= fetch_ptr + 1'b1;
            end else if (!mem_req && seek_valid && !seek_wr && (fifo_cnt < CW'(FIFO_DEPTH))) begin
                mem_req  <= 1'b1;
                mem_addr <= fetch_ptr;
            end
            if (seek_wr) begin
                fetch_ptr  <= DADDR_W'({DIN, seek});
                seek_valid <= 1'b1;
                drop_ack   <= mem_req && !mem_ack;
                data_busy  <= 1'b1;
            end else if (fifo_cnt != '0) begin
                data_busy  <= 1'b0;
            end
        end
    end

    // Register writes later in this block override the FSM and playback-stop updates.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= ST_IDLE;
            track_lo      <= '0;
            track_out     <= '0;
            track_request <= 1'b0;
            trig_play     <= 1'b0;
            trig_pause    <= 1'b0;
            volume_out    <= '0;
            rpt           <= 1'b0;
            playing       <= 1'b0;
            missing       <= 1'b0;
        end else begin
            track_request <= 1'b0;
            trig_play     <= 1'b0;
            trig_pause    <= 1'b0;
            if (audio_playing_1 && !audio_playing) playing <= 1'b0;
            case (state)
                ST_REQ:   if (track_mounting) state <= ST_MOUNT;
                ST_MOUNT: if (!track_mounting) begin
                    state   <= track_missing ? ST_MISSING : ST_READY;
                    missing <= track_missing;
                end
                default:  ;
            endcase
            if (wr_strobe) begin
                case (off)
                    OFF_TRACK_LO: track_lo <= DIN;
                    OFF_TRACK_HI: begin
                        track_out     <= TRACK_W'({DIN, track_lo});
                        track_request <= 1'b1;
                        playing       <= 1'b0;
                        rpt           <= 1'b0;
                        missing       <= 1'b0;
                        state         <= ST_REQ;
                    end
                    OFF_VOLUME:   volume_out <= DIN;
                    OFF_CONTROL:  if (!audio_busy) begin
                        rpt <= DIN[1];
                        if (state == ST_READY && track_out != '0) begin
                            playing    <= DIN[0];
                            trig_play  <= DIN[0];
                            trig_pause <= !DIN[0];
                        end
                    end
                    default:      ;
                endcase
            end
        end
    end

    always_comb begin
        status                  = 8'h00;
        status[2:0]             = REV;
        status[STAT_DATA_BUSY]  = data_busy;
        status[STAT_AUDIO_BUSY] = audio_busy;
        status[STAT_REPEAT]     = rpt;
        status[STAT_PLAYING]    = playing;
        status[STAT_MISSING]    = missing;
        case (off)
            OFF_STATUS: rd_mux = status;
            OFF_DATA:   rd_mux = (fifo_cnt != '0) ? fifo_dout : 8'h00;
            default:    rd_mux = MSU_ID[off];
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                DOUT <= 8'h00;
        else if (!RD_N && sel)  DOUT <= rd_mux;
    end

`ifdef MSU_DEBUG_EN
    assign dbg_state    = state;
    assign dbg_fifo_cnt = fifo_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                          dbg_last_reg <= 8'h00;
        else if (wr_strobe)               dbg_last_reg <= {5'b10000, off};
        else if (rd_n_1 && !RD_N && sel)  dbg_last_reg <= {5'b00000, off};
    end
`endif

endmodule
